instr_fetch_64: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction register. Owns the PC,

---
 rtl/instr_fetch_64.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_64.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_64.sv
// Instruction fetch stage: owns the PC, issues one word read per fetch over
// req/gnt/rvalid and hands the returned word to the IR with a load strobe.
module instr_fetch_64 #(
  parameter int                 ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fault_clr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instruction,
  output logic              load_ir,
  output logic              fetch_busy,
  output logic              fetch_fault,
  output logic [1:0]        fault_cause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FAULT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_n;
  logic [1:0]        cause_n;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic [7:0]        cnt;
  logic              tmo;
  logic              done;
  logic              fault_entry;

  assign mem_req    = (state == S_REQ);
  assign mem_addr   = fetch_addr;
  assign fetch_busy = (state == S_REQ) || (state == S_WAIT);
  assign start_addr = pc_load ? pc_in : pc;
  assign tmo        = (cnt >= TO_LAST);
  assign done       = (state == S_WAIT) && mem_rvalid && !mem_err;

  always_comb begin
    state_n = state;
    cause_n = 2'd0;
    unique case (state)
      S_IDLE: begin
        if (fetch_start) begin
          if (start_addr[1:0] != 2'b00) begin
            state_n = S_FAULT;
            cause_n = 2'd1;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_n = S_WAIT;
        end else if (tmo) begin
          state_n = S_FAULT;
          cause_n = 2'd3;
        end
      end
      S_WAIT: begin
        // a response arriving on the timeout cycle still counts
        if (mem_rvalid) begin
          if (mem_err) begin
            state_n = S_FAULT;
            cause_n = 2'd2;
          end else begin
            state_n = S_IDLE;
          end
        end else if (tmo) begin
          state_n = S_FAULT;
          cause_n = 2'd3;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign fault_entry = (state != S_FAULT) && (state_n == S_FAULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      fetch_addr  <= '0;
      pending     <= 1'b0;
      pending_pc  <= '0;
      cnt         <= 8'd0;
      instruction <= 32'd0;
      load_ir     <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= 2'd0;
    end else begin
      load_ir <= done;
      if (done) begin
        instruction <= mem_rdata;
        if (pc_load) begin
          pc <= pc_in;
        end else if (pending) begin
          pc <= pending_pc;
        end else begin
          pc <= fetch_addr + ADDR_W'(4);
        end
      end else if (pc_load && !fetch_busy) begin
        pc <= pc_in;
      end

      if (fault_entry || done) begin
        pending <= 1'b0;
      end else if (pc_load && fetch_busy) begin
        pending    <= 1'b1;
        pending_pc <= pc_in;
      end

      if (state == S_IDLE && state_n == S_REQ) begin
        fetch_addr <= start_addr;
      end

      if (state == S_IDLE) begin
        cnt <= 8'd0;
      end else if (fetch_busy) begin
        cnt <= cnt + 8'd1;
      end

      if (fault_entry) begin
        fetch_fault <= 1'b1;
        fault_cause <= cause_n;
      end else if (state == S_FAULT && fault_clr) begin
        fetch_fault <= 1'b0;
        fault_cause <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_64.sv
// Directed bench for instr_fetch_64 with a short timeout so the
// timeout path is reachable quickly.
module tb_instr_fetch_64;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic        pc_load;
  logic [63:0] pc_in;
  logic        fault_clr;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        load_ir;
  logic        fetch_busy;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad   = 0;

  instr_fetch_64 #(
    .ADDR_W  (64),
    .RESET_PC(64'h0),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_start(fetch_start),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .fault_clr  (fault_clr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .pc         (pc),
    .instruction(instruction),
    .load_ir    (load_ir),
    .fetch_busy (fetch_busy),
    .fetch_fault(fetch_fault),
    .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    fetch_start = 0; pc_load = 0; fault_clr = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
  endtask

  initial begin
    reset = 0; pc_in = '0; mem_rdata = '0;
    idle_in();
    #12;
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", {32'h0, instruction}, 64'h0);
    chk("rst_load", {63'h0, load_ir}, 64'h0);
    chk("rst_req", {63'h0, mem_req}, 64'h0);
    chk("rst_busy", {63'h0, fetch_busy}, 64'h0);
    chk("rst_fault", {62'h0, fetch_fault, fault_cause}, 64'h0);
    reset = 1;
    step();

    // 1: basic fetch, 3-cycle latency
    fetch_start = 1;
    step();
    fetch_start = 0;
    chk("t1_req", {63'h0, mem_req}, 64'h1);
    chk("t1_addr", mem_addr, 64'h0);
    chk("t1_busy", {63'h0, fetch_busy}, 64'h1);
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("t1_req_drop", {63'h0, mem_req}, 64'h0);
    chk("t1_noload", {63'h0, load_ir}, 64'h0);
    mem_rvalid = 1; mem_rdata = 32'h8C220004;
    step();
    mem_rvalid = 0;
    chk("t1_load", {63'h0, load_ir}, 64'h1);
    chk("t1_instr", {32'h0, instruction}, 64'h8C220004);
    chk("t1_pc", pc, 64'h4);
    chk("t1_idle", {63'h0, fetch_busy}, 64'h0);
    step();
    chk("t1_pulse", {63'h0, load_ir}, 64'h0);
    chk("t1_hold", {32'h0, instruction}, 64'h8C220004);

    // 2: redirect during WAIT applied at completion
    fetch_start = 1;
    step();
    fetch_start = 0;
    chk("t2_addr", mem_addr, 64'h4);
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    pc_load = 1; pc_in = 64'h100;
    step();
    pc_load = 0;
    chk("t2_pc_wait", pc, 64'h4);
    mem_rvalid = 1; mem_rdata = 32'h00112233;
    step();
    mem_rvalid = 0;
    chk("t2_pc", pc, 64'h100);
    fetch_start = 1;
    step();
    fetch_start = 0;
    chk("t2_addr2", mem_addr, 64'h100);
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00112233;
    step();
    mem_rvalid = 0;
    chk("t2_pc2", pc, 64'h104);

    // 3: misaligned redirect with fetch_start
    pc_load = 1; pc_in = 64'h102; fetch_start = 1;
    step();
    pc_load = 0; fetch_start = 0;
    chk("t3_req", {63'h0, mem_req}, 64'h0);
    chk("t3_fault", {63'h0, fetch_fault}, 64'h1);
    chk("t3_cause", {62'h0, fault_cause}, 64'h1);
    chk("t3_pc", pc, 64'h102);
    fetch_start = 1;
    step();
    fetch_start = 0;
    chk("t3_ignored", {63'h0, mem_req}, 64'h0);
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("t3_clr", {61'h0, fetch_fault, fault_cause}, 64'h0);
    pc_load = 1; pc_in = 64'h200;
    step();
    pc_load = 0;
    chk("t3_reload", pc, 64'h200);

    // 4: bus error
    fetch_start = 1;
    step();
    fetch_start = 0; mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_err = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 0; mem_err = 0;
    chk("t4_cause", {62'h0, fault_cause}, 64'h2);
    chk("t4_fault", {63'h0, fetch_fault}, 64'h1);
    chk("t4_noload", {63'h0, load_ir}, 64'h0);
    chk("t4_instr", {32'h0, instruction}, 64'h00112233);
    chk("t4_pc", pc, 64'h200);
    fault_clr = 1;
    step();
    fault_clr = 0;

    // 5: timeout with no grant
    fetch_start = 1;
    step();
    fetch_start = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_req%0d", i), {63'h0, mem_req}, 64'h1);
      step();
    end
    chk("t5_req_low", {63'h0, mem_req}, 64'h0);
    chk("t5_cause", {62'h0, fault_cause}, 64'h3);
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55555555;
    step();
    mem_rvalid = 0;
    chk("t5_late", {63'h0, load_ir}, 64'h0);
    chk("t5_instr", {32'h0, instruction}, 64'h00112233);
    chk("t5_still", {62'h0, fault_cause}, 64'h3);
    fault_clr = 1;
    step();
    fault_clr = 0;

    // 6: pc wrap, then reset in WAIT
    pc_load = 1; pc_in = 64'hFFFF_FFFF_FFFF_FFFC; fetch_start = 1;
    step();
    pc_load = 0; fetch_start = 0;
    chk("t6_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    mem_rvalid = 0;
    chk("t6_wrap", pc, 64'h0);
    chk("t6_instr", {32'h0, instruction}, 64'hA5A5A5A5);
    fetch_start = 1;
    step();
    fetch_start = 0; mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("t6_wait", {63'h0, fetch_busy}, 64'h1);
    reset = 0;
    #1;
    chk("t6_rst_busy", {63'h0, fetch_busy}, 64'h0);
    chk("t6_rst_instr", {32'h0, instruction}, 64'h0);
    chk("t6_rst_pc", pc, 64'h0);
    step();
    reset = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
    step();
    mem_rvalid = 0;
    chk("t6_noload", {63'h0, load_ir}, 64'h0);
    chk("t6_instr0", {32'h0, instruction}, 64'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
